seg_scan_ctrl: RTL and testbench

Scan controller that sequences the 12-bit seven-segment conduit of the `mypio` peripheral: four multiplexed digits, 8 segment lines and 4 digit selects. It accepts a display word from the HPS-facing register side over a valid/ready handshake and holds it in a single-entry pending buffer. The word becomes active only at a frame boundary, so no frame ever shows a mix of old and new digits. Each digit is driven for a fixed dwell, followed by an all-off blanking gap that suppresses ghosting.

---
 rtl/seg_scan_pkg.sv | 46 ++++
 rtl/seg_scan_ctrl_dec.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared types, constants and the hex-to-segment table for
//                the seven-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = 7'h7F;
    case (nibble)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg_dec
//  Description : Combinational nibble + dp + blank to active-low segment byte
//                {dp,g,f,e,d,c,b,a}. Blanking kills a-g only; dp is separate.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [6:0] w_pat;

  assign w_pat = blank ? SEG_OFF[6:0] : hex2seg(nibble);
  assign seg   = {~dp, w_pat};

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Four-digit multiplexed seven-segment scan controller with a
//                single-entry pending buffer that only goes live at a frame
//                boundary, fixed per-digit dwell and an all-off blanking gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_digits,
  input  logic [3:0]  wr_dp,
  input  logic        wr_lzb,
  output logic [11:0] seg_output,
  output logic        frame_done
);

  localparam int c_max_cycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles);
  localparam logic [c_cnt_w-1:0] c_digit_last = c_cnt_w'(DIGIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);

  state_t               r_state;
  logic [1:0]           r_idx;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [15:0]          r_act_digits;
  logic [3:0]           r_act_dp;
  logic                 r_act_lzb;
  logic [15:0]          r_pend_digits;
  logic [3:0]           r_pend_dp;
  logic                 r_pend_lzb;
  logic                 r_pend_v;

  logic                 w_digit_end;
  logic                 w_blank_end;
  logic                 w_boundary;
  logic                 w_accept;
  logic [3:0]           w_nibble;
  logic [3:0]           w_lz;
  logic                 w_blank;
  logic                 w_dp;
  logic [3:0]           w_sel;
  logic [7:0]           w_seg;

  assign wr_ready    = ~r_pend_v;
  assign w_accept    = wr_valid & ~r_pend_v;
  assign w_digit_end = (r_cnt == c_digit_last);
  assign w_blank_end = (r_cnt == c_blank_last);

  // A frame starts either when scanning is (re)enabled from IDLE or when the
  // blanking gap after digit 3 expires; only then may the displayed word change.
  assign w_boundary = enable &
                      ((r_state == IDLE) |
                       ((r_state == BLANK) & w_blank_end & (r_idx == 2'd3)));

  // Leading-zero chain: digit k is a leading zero when nibbles k..3 are all 0.
  // Digit 0 is always shown so a value of zero still reads "0".
  assign w_lz[3] = (r_act_digits[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] & (r_act_digits[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] & (r_act_digits[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;

  assign w_nibble = r_act_digits[{r_idx, 2'b00} +: 4];
  assign w_blank  = r_act_lzb & w_lz[r_idx];
  assign w_dp     = r_act_dp[r_idx];
  assign w_sel    = ~(4'b0001 << r_idx);

  hex7seg_dec u_dec (
    .nibble (w_nibble),
    .dp     (w_dp),
    .blank  (w_blank),
    .seg    (w_seg)
  );

  // Pending/active double buffer: accept into pending, promote at a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_digits  <= 16'h0000;
      r_act_dp      <= 4'h0;
      r_act_lzb     <= 1'b0;
      r_pend_digits <= 16'h0000;
      r_pend_dp     <= 4'h0;
      r_pend_lzb    <= 1'b0;
      r_pend_v      <= 1'b0;
    end else begin
      if (w_boundary && r_pend_v) begin
        r_act_digits <= r_pend_digits;
        r_act_dp     <= r_pend_dp;
        r_act_lzb    <= r_pend_lzb;
        r_pend_v     <= 1'b0;
      end
      // Accept needs an empty buffer, so it never coincides with a promotion.
      if (w_accept) begin
        r_pend_digits <= wr_digits;
        r_pend_dp     <= wr_dp;
        r_pend_lzb    <= wr_lzb;
        r_pend_v      <= 1'b1;
      end
    end
  end

  // Scan FSM; select and segments are registered together from the current
  // state so the pair always changes on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      seg_output <= {SEL_OFF, SEG_OFF};
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        r_state    <= IDLE;
        r_idx      <= 2'd0;
        r_cnt      <= '0;
        seg_output <= {SEL_OFF, SEG_OFF};
      end else begin
        case (r_state)
          IDLE: begin
            seg_output <= {SEL_OFF, SEG_OFF};
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_state    <= SHOW;
          end
          SHOW: begin
            seg_output <= {w_sel, w_seg};
            if (w_digit_end) begin
              r_cnt   <= '0;
              r_state <= BLANK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          BLANK: begin
            seg_output <= {SEL_OFF, SEG_OFF};
            if (w_blank_end) begin
              r_cnt      <= '0;
              r_idx      <= r_idx + 2'd1;
              r_state    <= SHOW;
              frame_done <= (r_idx == 2'd3);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            seg_output <= {SEL_OFF, SEG_OFF};
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Directed self-checking bench for seg_scan_ctrl with an
//                8-cycle digit dwell and 2-cycle blank (40-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_digits;
  logic [3:0]  wr_dp;
  logic        wr_lzb;
  logic [11:0] seg_output;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digits  (wr_digits),
    .wr_dp      (wr_dp),
    .wr_lzb     (wr_lzb),
    .seg_output (seg_output),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walks one frame from cycle 'start' (0 = first cycle digit 0 is visible)
  // and checks every output cycle plus the frame_done pulse on cycle 39.
  task automatic check_frame(input string name, input logic [11:0] d0, input logic [11:0] d1,
                             input logic [11:0] d2, input logic [11:0] d3, input int start);
    logic [11:0] d [4];
    logic [11:0] exp;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int c = start; c < 40; c++) begin
      exp = ((c % 10) < 8) ? d[c / 10] : 12'hFFF;
      check($sformatf("%s seg c%0d", name, c), seg_output, exp);
      check($sformatf("%s frame_done c%0d", name, c), {11'b0, frame_done},
            (c == 39) ? 12'd1 : 12'd0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; wr_valid = 1'b0;
    wr_digits = 16'h0000; wr_dp = 4'h0; wr_lzb = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst seg", seg_output, 12'hFFF);
    check("rst wr_ready", {11'b0, wr_ready}, 12'd1);
    check("rst frame_done", {11'b0, frame_done}, 12'd0);

    reset_n = 1'b1;
    tick();
    check("idle seg", seg_output, 12'hFFF);

    // First frame, no write: all zeros
    enable = 1'b1;
    tick();
    check("idle->show seg", seg_output, 12'hFFF);
    tick();
    check_frame("F1", 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, 0);

    // Double buffering: write 1234 one cycle into the frame
    wr_valid = 1'b1; wr_digits = 16'h1234; wr_dp = 4'h0; wr_lzb = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("dbuf wr_ready busy", {11'b0, wr_ready}, 12'd0);
    check_frame("F2", 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, 1);
    check("dbuf wr_ready freed", {11'b0, wr_ready}, 12'd1);
    check_frame("F3", 12'hE99, 12'hDB0, 12'hBA4, 12'h7F9, 0);

    // Backpressure: A=00AF then B=0005 held on the bus
    wr_valid = 1'b1; wr_digits = 16'h00AF;
    tick();
    wr_digits = 16'h0005;
    check("bp B stalled", {11'b0, wr_ready}, 12'd0);
    check_frame("F4", 12'hE99, 12'hDB0, 12'hBA4, 12'h7F9, 1);
    check("bp B taken", {11'b0, wr_ready}, 12'd0);
    wr_valid = 1'b0;
    check_frame("F5", 12'hE8E, 12'hD88, 12'hBC0, 12'h7C0, 0);
    check("bp B live", {11'b0, wr_ready}, 12'd1);

    // Leading-zero blanking with dp on digit 0
    wr_valid = 1'b1; wr_digits = 16'h0050; wr_dp = 4'b0001; wr_lzb = 1'b1;
    tick();
    wr_valid = 1'b0;
    check_frame("F6", 12'hE92, 12'hDC0, 12'hBC0, 12'h7C0, 1);
    check_frame("F7", 12'hE40, 12'hD92, 12'hBFF, 12'h7FF, 0);

    // Enable drop mid-SHOW with a word waiting in pending
    wr_valid = 1'b1; wr_digits = 16'h0008; wr_dp = 4'h0; wr_lzb = 1'b0;
    tick();
    wr_valid = 1'b0;
    repeat (3) tick();
    check("en show before drop", seg_output, 12'hE40);
    enable = 1'b0;
    tick();
    check("en drop seg", seg_output, 12'hFFF);
    check("en drop frame_done", {11'b0, frame_done}, 12'd0);
    repeat (2) tick();
    check("en off seg", seg_output, 12'hFFF);
    check("en off pending kept", {11'b0, wr_ready}, 12'd0);
    enable = 1'b1;
    tick();
    check("re-en seg", seg_output, 12'hFFF);
    check("re-en loaded", {11'b0, wr_ready}, 12'd1);
    tick();
    check_frame("F8", 12'hE80, 12'hDC0, 12'hBC0, 12'h7C0, 0);

    // Reset pulse mid-frame discards the pending word
    wr_valid = 1'b1; wr_digits = 16'h9999;
    tick();
    wr_valid = 1'b0;
    check("rst2 pending", {11'b0, wr_ready}, 12'd0);
    repeat (3) tick();
    check("rst2 pre seg", seg_output, 12'hE80);
    reset_n = 1'b0;
    #1;
    check("rst2 async seg", seg_output, 12'hFFF);
    check("rst2 async wr_ready", {11'b0, wr_ready}, 12'd1);
    check("rst2 async frame_done", {11'b0, frame_done}, 12'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst2 restart seg", seg_output, 12'hFFF);
    tick();
    check_frame("F9", 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
